feature_cache_writer: RTL
=========================

Name: feature_cache_writer

Overview:
Upstream stage of the feature cache. It accepts one feature descriptor per valid/ready handshake from the feature detector. Each descriptor is serialised into FEAT_WORDS consecutive cache words, which are written through the cache write port (waddr/wdata/we). The block counts the stored features per frame, flags overflow when the cache is full, and pulses done at frame end so that downstream readers can start.

Parameters:
ADDR_WIDTH, 10, cache address width.
WORD_SIZE, 8, cache word width in bits.
WORDS, 1024, cache depth in words.
FEAT_WORDS, 4, cache words per feature descriptor (>=1).
MAX_FEATS, WORDS/FEAT_WORDS, feature capacity per frame.
COUNT_W, $clog2(MAX_FEATS+1), feature counter width.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
frame_start  in  1  single-cycle pulse that starts a new frame.
frame_end  in  1  single-cycle pulse; no more features will arrive this frame.
feat_valid  in  1  descriptor valid.
feat_ready  out  1  block can accept a descriptor.
feat_data  in  FEAT_WORDS*WORD_SIZE  descriptor; word 0 is the LSBs.
cache_waddr  out  ADDR_WIDTH  cache write address (maps to fcw.waddr).
cache_wdata  out  WORD_SIZE  cache write data (maps to fcw.wdata).
cache_we  out  1  cache write enable (maps to fcw.we).
feat_count  out  COUNT_W  features stored in the current/last frame.
overflow  out  1  sticky per frame: at least one descriptor was dropped.
done  out  1  single-cycle pulse when the frame's features are all written.

Behaviour:
- One clock, clk. rst is synchronous and active-high, and it overrides every other input.
- Reset values: state IDLE; feat_ready=0, cache_we=0, cache_waddr=0, cache_wdata=0, feat_count=0, overflow=0, done=0, end_pending=0.
- States are IDLE, ACCEPT, WRITE and DONE.
- IDLE:
  - feat_ready=0.
  - frame_start -> ACCEPT; clear feat_count, overflow and end_pending.
- ACCEPT:
  - feat_ready=1, decoded combinationally from the state.
  - feat_valid&&feat_ready with feat_count<MAX_FEATS: latch feat_data into the shift register, word_idx=0 -> WRITE.
  - Same handshake with feat_count==MAX_FEATS: descriptor dropped, overflow<=1, stay in ACCEPT. Dropping keeps the upstream detector from stalling.
  - frame_end (no accept this cycle) -> DONE.
  - frame_end in the same cycle as an accepted descriptor: the descriptor is written, end_pending<=1, then DONE after its last word.
- WRITE:
  - feat_ready=0.
  - cache outputs are registered. Write k (k=0..FEAT_WORDS-1) drives cache_we=1, cache_waddr=feat_count*FEAT_WORDS+k and cache_wdata=descriptor word k.
  - Latency: accept in cycle t -> writes in cycles t+1 .. t+FEAT_WORDS, contiguous.
  - After the last word: feat_count++. Next state is DONE if end_pending, otherwise ACCEPT.
  - frame_end arriving during WRITE sets end_pending.
  - Throughput: one descriptor per FEAT_WORDS+1 cycles.
- DONE:
  - done=1 for exactly one cycle -> IDLE.
  - feat_count and overflow hold until the next frame_start.
- cache_we=0 in every cycle that is not a WRITE cycle; cache_waddr and cache_wdata hold their last values.
- Address arithmetic: feat_count*FEAT_WORDS+k never exceeds WORDS-1, and no wrap-around is permitted.
- frame_start in ACCEPT, WRITE or DONE aborts the current frame immediately:
  - Any partial descriptor writes already issued stay in the cache.
  - The in-flight write sequence is cancelled; cache_we=0 from the next cycle.
  - feat_count, overflow and end_pending are cleared, and the state goes to ACCEPT. No done pulse is produced for the aborted frame.
- frame_end in IDLE or DONE is ignored.
- rst mid-WRITE: the next cycle shows reset values, with cache_we=0.

Decomposition:
- pkg_featureCache carries the shared constants ADDR_WIDTH, WORD_SIZE and WORDS, plus new FEAT_WORDS and MAX_FEATS. It also holds the state enum typedef state_fcw_t.
- structs gains struct_featureDescriptor (valid, data), so the detector-to-writer link can be passed as one struct.
- The cache_* outputs are assembled into structs::struct_featureCache_Write at the integration level.
- No sub-module: the serialiser is a shift register plus word_idx counter inside this block.

Test Plan:
- Reset/idle: rst for 2 cycles, then idle -> all outputs 0; feat_valid=1 in IDLE -> feat_ready=0 and no writes.
- Single feature: frame_start, then feat_data=0xDDCCBBAA with feat_valid -> writes (0,AA),(1,BB),(2,CC),(3,DD) in cycles t+1..t+4; feat_count=1.
- End handling:
  - frame_end in the same cycle as the accept of feature #0 -> 4 writes, then done 1 cycle later; feat_count=1.
  - frame_end during WRITE -> done only after the 4th write.
- Back-to-back: 3 features with feat_valid held high -> feat_ready pattern 1,0,0,0,0 repeating; addresses 0..11 contiguous; feat_count=3.
- Overflow: 257 features -> addresses 0..1023 written; the 257th descriptor is dropped with no write; overflow=1; feat_count=256; done after frame_end.
- Abort: frame_start during the 2nd write of feature #5 -> cache_we=0 next cycle; feat_count=0; the next feature is written at address 0; no done pulse for the aborted frame.

Source files
------------

// File: rtl/feature_cache_writer_pkg.sv
// -----------------------------------------------------------------------------
// feature_cache_writer_pkg
// Shared constants and types for the feature cache write path:
//   - cache geometry (address width, word size, depth)
//   - descriptor geometry (words per feature, feature capacity)
//   - writer FSM state encoding
//   - detector-to-writer descriptor struct and cache write-port struct, used
//     when the links are bundled at the integration level
// -----------------------------------------------------------------------------
package feature_cache_writer_pkg;

    localparam int FCW_ADDR_WIDTH = 10;
    localparam int FCW_WORD_SIZE  = 8;
    localparam int FCW_WORDS      = 1024;
    localparam int FCW_FEAT_WORDS = 4;
    localparam int FCW_MAX_FEATS  = FCW_WORDS / FCW_FEAT_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_fcw_t;

    typedef struct packed {
        logic                                      valid;
        logic [FCW_FEAT_WORDS*FCW_WORD_SIZE-1:0]   data;
    } struct_featureDescriptor;

    typedef struct packed {
        logic [FCW_ADDR_WIDTH-1:0] waddr;
        logic [FCW_WORD_SIZE-1:0]  wdata;
        logic                      we;
    } struct_featureCache_Write;

endpackage

// File: rtl/feature_cache_writer.sv
// -----------------------------------------------------------------------------
// feature_cache_writer
// Accepts feature descriptors over a valid/ready handshake and serialises each
// one into FEAT_WORDS consecutive cache words (word 0 = descriptor LSBs).
// Counts stored features per frame, flags dropped descriptors once the cache
// is full, and pulses done when the frame's features are all written.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   frame_start           pulse: start (or restart) a frame
//   frame_end             pulse: no more descriptors this frame
//   feat_valid/feat_ready descriptor handshake
//   feat_data             descriptor, FEAT_WORDS*WORD_SIZE bits
//   cache_waddr/wdata/we  registered cache write port
//   feat_count            features stored in the current/last frame
//   overflow              sticky per frame: a descriptor was dropped
//   done                  one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module feature_cache_writer
    import feature_cache_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = FCW_ADDR_WIDTH,
    parameter int WORD_SIZE  = FCW_WORD_SIZE,
    parameter int WORDS      = FCW_WORDS,
    parameter int FEAT_WORDS = FCW_FEAT_WORDS,
    parameter int MAX_FEATS  = WORDS / FEAT_WORDS,
    parameter int COUNT_W    = $clog2(MAX_FEATS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start,
    input  logic                            frame_end,
    input  logic                            feat_valid,
    output logic                            feat_ready,
    input  logic [FEAT_WORDS*WORD_SIZE-1:0] feat_data,
    output logic [ADDR_WIDTH-1:0]           cache_waddr,
    output logic [WORD_SIZE-1:0]            cache_wdata,
    output logic                            cache_we,
    output logic [COUNT_W-1:0]              feat_count,
    output logic                            overflow,
    output logic                            done
);

    localparam int IDX_W = (FEAT_WORDS > 1) ? $clog2(FEAT_WORDS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(FEAT_WORDS - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT  = COUNT_W'(MAX_FEATS);

    state_fcw_t                       state_q, state_d;
    logic [COUNT_W-1:0]               feat_count_q, feat_count_d;
    logic                             overflow_q, overflow_d;
    logic                             end_pending_q, end_pending_d;
    logic [IDX_W-1:0]                 word_idx_q, word_idx_d;
    logic [FEAT_WORDS*WORD_SIZE-1:0]  shreg_q, shreg_d;
    logic                             cache_we_q, cache_we_d;
    logic [ADDR_WIDTH-1:0]            cache_waddr_q, cache_waddr_d;
    logic [WORD_SIZE-1:0]             cache_wdata_q, cache_wdata_d;
    logic [ADDR_WIDTH-1:0]            base_addr;

    // First word address of the next descriptor; feat_count < MAX_FEATS when
    // used, so this stays within the cache without wrapping.
    assign base_addr = ADDR_WIDTH'(feat_count_q) * ADDR_WIDTH'(FEAT_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            feat_count_q  <= '0;
            overflow_q    <= 1'b0;
            end_pending_q <= 1'b0;
            word_idx_q    <= '0;
            cache_we_q    <= 1'b0;
            cache_waddr_q <= '0;
            cache_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            feat_count_q  <= feat_count_d;
            overflow_q    <= overflow_d;
            end_pending_q <= end_pending_d;
            word_idx_q    <= word_idx_d;
            cache_we_q    <= cache_we_d;
            cache_waddr_q <= cache_waddr_d;
            cache_wdata_q <= cache_wdata_d;
        end
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d       = state_q;
        feat_count_d  = feat_count_q;
        overflow_d    = overflow_q;
        end_pending_d = end_pending_q;
        word_idx_d    = word_idx_q;
        shreg_d       = shreg_q;
        cache_we_d    = 1'b0;
        cache_waddr_d = cache_waddr_q;
        cache_wdata_d = cache_wdata_q;

        if (frame_start) begin
            // Start or abort: any in-flight write sequence is cancelled here.
            state_d       = ST_ACCEPT;
            feat_count_d  = '0;
            overflow_d    = 1'b0;
            end_pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ACCEPT: begin
                    if (feat_valid) begin
                        if (feat_count_q < MAX_CNT) begin
                            // Word 0 goes straight to the write port; the
                            // remaining words wait in the shift register.
                            cache_we_d    = 1'b1;
                            cache_waddr_d = base_addr;
                            cache_wdata_d = feat_data[WORD_SIZE-1:0];
                            shreg_d       = feat_data >> WORD_SIZE;
                            word_idx_d    = '0;
                            state_d       = ST_WRITE;
                            if (frame_end) begin
                                end_pending_d = 1'b1;
                            end
                        end else begin
                            // Cache full: drop rather than stall the detector.
                            overflow_d = 1'b1;
                            if (frame_end) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else if (frame_end) begin
                        state_d = ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (frame_end) begin
                        end_pending_d = 1'b1;
                    end
                    if (word_idx_q == LAST_IDX) begin
                        feat_count_d = feat_count_q + COUNT_W'(1);
                        state_d      = (end_pending_q || frame_end) ? ST_DONE : ST_ACCEPT;
                    end else begin
                        cache_we_d    = 1'b1;
                        cache_waddr_d = cache_waddr_q + ADDR_WIDTH'(1);
                        cache_wdata_d = shreg_q[WORD_SIZE-1:0];
                        shreg_d       = shreg_q >> WORD_SIZE;
                        word_idx_d    = word_idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign feat_ready  = (state_q == ST_ACCEPT);
    assign done        = (state_q == ST_DONE);
    assign cache_we    = cache_we_q;
    assign cache_waddr = cache_waddr_q;
    assign cache_wdata = cache_wdata_q;
    assign feat_count  = feat_count_q;
    assign overflow    = overflow_q;

endmodule
